// File: rtl/frame_pkg.sv
// Types and constants shared by the frame receiver and transmitter.
package frame_pkg;

  localparam int FRAME_DATA_LNGTH = 162;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for one asynchronous bit.
// Latency: 2 cycles. No backpressure.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/frame_rx.sv
// Serial frame receiver: start 0, DATA_LNGTH bits LSB first, stop 1; pulses valid_out one cycle after the stop sample.
// No backpressure. Define FRAME_RX_FRAMING_CHECK_EN to reject frames with a bad stop bit (error_out pulse).
module frame_rx
  import frame_pkg::*;
#(
  parameter int DIVISOR    = 10416,
  parameter int DATA_LNGTH = FRAME_DATA_LNGTH
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  data_in,
  output logic [DATA_LNGTH-1:0] val_out,
  output logic                  valid_out,
  output logic                  error_out,
  output logic                  busy_out
);

  localparam int IW = (DATA_LNGTH > 1) ? $clog2(DATA_LNGTH) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(DATA_LNGTH - 1);

  logic                  line;
  logic                  line_prev;
  rx_state_t             state;
  logic [31:0]           cnt;
  logic [IW-1:0]         idx;
  logic [DATA_LNGTH-1:0] payload;

  sync_2ff u_sync (
    .clk (clk_in),
    .rst (rst_in),
    .d   (data_in),
    .q   (line)
  );

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state     <= IDLE;
      cnt       <= '0;
      idx       <= '0;
      payload   <= '0;
      line_prev <= 1'b0;
      val_out   <= '0;
      valid_out <= 1'b0;
      error_out <= 1'b0;
      busy_out  <= 1'b0;
    end else begin
      line_prev <= line;
      valid_out <= 1'b0;
      error_out <= 1'b0;
      case (state)
        IDLE: begin
          // History resets to 0, so a line held low out of reset needs a rising edge first.
          if (line_prev && !line) begin
            state    <= START;
            cnt      <= 32'(DIVISOR / 2 - 1);
            busy_out <= 1'b1;
          end
        end
        START: begin
          if (cnt == 32'd0) begin
            if (!line) begin
              state <= DATA;
              cnt   <= 32'(DIVISOR - 1);
              idx   <= '0;
            end else begin
              state    <= IDLE;
              busy_out <= 1'b0;
            end
          end else begin
            cnt <= cnt - 32'd1;
          end
        end
        DATA: begin
          if (cnt == 32'd0) begin
            payload[idx] <= line;
            cnt          <= 32'(DIVISOR - 1);
            if (idx == LAST_IDX) begin
              state <= STOP;
            end else begin
              idx <= idx + 1'b1;
            end
          end else begin
            cnt <= cnt - 32'd1;
          end
        end
        STOP: begin
          if (cnt == 32'd0) begin
            state    <= IDLE;
            busy_out <= 1'b0;
`ifdef FRAME_RX_FRAMING_CHECK_EN
            if (line) begin
              val_out   <= payload;
              valid_out <= 1'b1;
            end else begin
              error_out <= 1'b1;
            end
`else
            val_out   <= payload;
            valid_out <= 1'b1;
`endif
          end else begin
            cnt <= cnt - 32'd1;
          end
        end
        default: begin
          state    <= IDLE;
          busy_out <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_frame_rx.sv
// Directed self-checking bench for frame_rx with DIVISOR=16, DATA_LNGTH=162.
module tb_frame_rx;

  localparam int DIV = 16;
  localparam int DL  = 162;

  logic          clk_in  = 1'b0;
  logic          rst_in  = 1'b1;
  logic          data_in = 1'b1;
  logic [DL-1:0] val_out;
  logic          valid_out;
  logic          error_out;
  logic          busy_out;

  int tests = 0;
  int fails = 0;
  int vcnt  = 0;
  int ecnt  = 0;
  logic [DL-1:0] cap[$];
  logic [DL-1:0] exp_val;

  frame_rx #(.DIVISOR(DIV), .DATA_LNGTH(DL)) dut (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .data_in   (data_in),
    .val_out   (val_out),
    .valid_out (valid_out),
    .error_out (error_out),
    .busy_out  (busy_out)
  );

  always #5 clk_in = ~clk_in;

  // Pulse monitor: counts high cycles and captures val_out on each valid pulse.
  always @(negedge clk_in) begin
    if (valid_out) begin
      vcnt++;
      cap.push_back(val_out);
    end
    if (error_out) ecnt++;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_in);
      #1;
    end
  endtask

  task automatic send_bit(input logic b);
    data_in = b;
    tick(DIV);
  endtask

  task automatic send_frame(input logic [DL-1:0] p, input logic stop_b);
    send_bit(1'b0);
    for (int i = 0; i < DL; i++) send_bit(p[i]);
    send_bit(stop_b);
    data_in = 1'b1;
  endtask

  task automatic clear_mon();
    vcnt = 0;
    ecnt = 0;
    cap.delete();
  endtask

  task automatic test_reset();
    rst_in  = 1'b1;
    data_in = 1'b1;
    tick(3);
    tests++; if (val_out !== '0) begin fails++; $display("FAIL reset_val: got %h expected 0", val_out); end
    tests++; if (valid_out !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b expected 0", valid_out); end
    tests++; if (error_out !== 1'b0) begin fails++; $display("FAIL reset_error: got %b expected 0", error_out); end
    tests++; if (busy_out !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", busy_out); end
    rst_in = 1'b0;
    tick(10);
  endtask

  task automatic test_frame();
    logic [DL-1:0] p;
    p = {2'b10, {39{4'hA}}, 4'h5};
    clear_mon();
    send_bit(1'b0);
    tests++; if (busy_out !== 1'b1) begin fails++; $display("FAIL frame_busy: got %b expected 1", busy_out); end
    for (int i = 0; i < DL; i++) send_bit(p[i]);
    send_bit(1'b1);
    tick(4);
    tests++; if (vcnt !== 1) begin fails++; $display("FAIL frame_valid_cnt: got %0d expected 1", vcnt); end
    tests++; if (ecnt !== 0) begin fails++; $display("FAIL frame_error_cnt: got %0d expected 0", ecnt); end
    tests++; if (val_out !== p) begin fails++; $display("FAIL frame_val: got %h expected %h", val_out, p); end
    tests++; if (busy_out !== 1'b0) begin fails++; $display("FAIL frame_idle_busy: got %b expected 0", busy_out); end
    exp_val = p;
  endtask

  task automatic test_glitch();
    clear_mon();
    data_in = 1'b0;
    tick(4);
    tests++; if (busy_out !== 1'b1) begin fails++; $display("FAIL glitch_start_busy: got %b expected 1", busy_out); end
    data_in = 1'b1;
    tick(20);
    tests++; if (busy_out !== 1'b0) begin fails++; $display("FAIL glitch_busy: got %b expected 0", busy_out); end
    tests++; if (vcnt !== 0) begin fails++; $display("FAIL glitch_valid_cnt: got %0d expected 0", vcnt); end
    tests++; if (ecnt !== 0) begin fails++; $display("FAIL glitch_error_cnt: got %0d expected 0", ecnt); end
    tests++; if (val_out !== exp_val) begin fails++; $display("FAIL glitch_val: got %h expected %h", val_out, exp_val); end
  endtask

  task automatic test_bad_stop();
    logic [DL-1:0] p;
    p = {2'b01, {20{8'h3C}}};
    clear_mon();
    send_frame(p, 1'b0);
    tick(4);
`ifdef FRAME_RX_FRAMING_CHECK_EN
    tests++; if (ecnt !== 1) begin fails++; $display("FAIL badstop_error_cnt: got %0d expected 1", ecnt); end
    tests++; if (vcnt !== 0) begin fails++; $display("FAIL badstop_valid_cnt: got %0d expected 0", vcnt); end
    tests++; if (val_out !== exp_val) begin fails++; $display("FAIL badstop_val: got %h expected %h", val_out, exp_val); end
`else
    tests++; if (ecnt !== 0) begin fails++; $display("FAIL badstop_error_cnt: got %0d expected 0", ecnt); end
    tests++; if (vcnt !== 1) begin fails++; $display("FAIL badstop_valid_cnt: got %0d expected 1", vcnt); end
    tests++; if (val_out !== p) begin fails++; $display("FAIL badstop_val: got %h expected %h", val_out, p); end
    exp_val = p;
`endif
  endtask

  task automatic test_reset_mid();
    logic [DL-1:0] p;
    logic [DL-1:0] p2;
    p  = {2'b11, {40{4'h6}}};
    p2 = {2'b00, {10{16'hC0DE}}};
    clear_mon();
    send_bit(1'b0);
    for (int i = 0; i < 80; i++) send_bit(p[i]);
    data_in = p[80];
    tick(3);
    rst_in = 1'b1;
    tick(1);
    tests++; if (val_out !== '0) begin fails++; $display("FAIL midrst_val: got %h expected 0", val_out); end
    tests++; if (valid_out !== 1'b0) begin fails++; $display("FAIL midrst_valid: got %b expected 0", valid_out); end
    tests++; if (error_out !== 1'b0) begin fails++; $display("FAIL midrst_error: got %b expected 0", error_out); end
    tests++; if (busy_out !== 1'b0) begin fails++; $display("FAIL midrst_busy: got %b expected 0", busy_out); end
    data_in = 1'b1;
    tick(2);
    rst_in = 1'b0;
    tick(20);
    tests++; if (vcnt !== 0 || ecnt !== 0) begin fails++; $display("FAIL midrst_pulses: got valid %0d error %0d expected 0 0", vcnt, ecnt); end
    send_frame(p2, 1'b1);
    tick(4);
    tests++; if (vcnt !== 1) begin fails++; $display("FAIL midrst_next_cnt: got %0d expected 1", vcnt); end
    tests++; if (val_out !== p2) begin fails++; $display("FAIL midrst_next_val: got %h expected %h", val_out, p2); end
    exp_val = p2;
  endtask

  task automatic test_back_to_back();
    logic [DL-1:0] ones;
    logic [DL-1:0] zeros;
    ones  = '1;
    zeros = '0;
    clear_mon();
    send_frame(ones, 1'b1);
    send_frame(zeros, 1'b1);
    tick(4);
    tests++; if (vcnt !== 2) begin fails++; $display("FAIL b2b_valid_cnt: got %0d expected 2", vcnt); end
    tests++; if (ecnt !== 0) begin fails++; $display("FAIL b2b_error_cnt: got %0d expected 0", ecnt); end
    if (cap.size() >= 2) begin
      tests++; if (cap[0] !== ones) begin fails++; $display("FAIL b2b_first: got %h expected %h", cap[0], ones); end
      tests++; if (cap[1] !== zeros) begin fails++; $display("FAIL b2b_second: got %h expected %h", cap[1], zeros); end
    end
    tests++; if (val_out !== zeros) begin fails++; $display("FAIL b2b_final_val: got %h expected %h", val_out, zeros); end
    exp_val = zeros;
  endtask

  task automatic test_low_at_reset();
    logic [DL-1:0] p;
    p = {2'b10, {20{8'h81}}};
    clear_mon();
    rst_in  = 1'b1;
    data_in = 1'b0;
    tick(3);
    rst_in = 1'b0;
    tick(40);
    tests++; if (busy_out !== 1'b0) begin fails++; $display("FAIL lowrst_busy: got %b expected 0", busy_out); end
    tests++; if (vcnt !== 0 || ecnt !== 0) begin fails++; $display("FAIL lowrst_pulses: got valid %0d error %0d expected 0 0", vcnt, ecnt); end
    data_in = 1'b1;
    tick(20);
    send_frame(p, 1'b1);
    tick(4);
    tests++; if (vcnt !== 1) begin fails++; $display("FAIL lowrst_valid_cnt: got %0d expected 1", vcnt); end
    tests++; if (ecnt !== 0) begin fails++; $display("FAIL lowrst_error_cnt: got %0d expected 0", ecnt); end
    tests++; if (val_out !== p) begin fails++; $display("FAIL lowrst_val: got %h expected %h", val_out, p); end
  endtask

  initial begin
    exp_val = '0;
    test_reset();
    test_frame();
    test_glitch();
    test_bad_stop();
    test_reset_mid();
    test_back_to_back();
    test_low_at_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
